// File: rtl/lc3_uart_loader_pkg.sv
// Shared constants and state encodings for the LC-3 UART program loader.
package lc3_pkg;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [15:0] LC3_ORIGIN        = 16'h3000;

    typedef enum logic [3:0] {
        ST_HUNT   = 4'd0,
        ST_CNT_HI = 4'd1,
        ST_CNT_LO = 4'd2,
        ST_ORG_HI = 4'd3,
        ST_ORG_LO = 4'd4,
        ST_DAT_HI = 4'd5,
        ST_DAT_LO = 4'd6,
        ST_CSUM   = 4'd7,
        ST_RUN    = 4'd8
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/lc3_uart_loader_uart_rx.sv
// 8N1 UART receiver: one-cycle byte_valid or frame_err pulse per character.
// No backpressure; a byte is presented for exactly one cycle.
module uart_rx_byte
    import lc3_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    rx_state_t     r_state, w_nxt;
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid, r_ferr;
    logic          w_full, w_half;

    always_comb begin
        w_full = (r_cnt == FULL);
        w_half = (r_cnt == HALF);
        w_nxt  = r_state;
        case (r_state)
            RX_IDLE:  if (r_rx_d && !r_rx_s2) w_nxt = RX_START;
            RX_START: if (w_half) w_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_bit == 3'd7) w_nxt = RX_STOP;
            RX_STOP:  if (w_full) w_nxt = RX_IDLE;
            default:  w_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_state <= w_nxt;
            r_valid <= (r_state == RX_STOP) && w_full && r_rx_s2;
            r_ferr  <= (r_state == RX_STOP) && w_full && !r_rx_s2;
            // Counter restarts on every state change and after each data-bit sample.
            if (r_state == RX_IDLE || w_nxt != r_state || (r_state == RX_DATA && w_full))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == RX_START) begin
                r_bit <= 3'd0;
            end else if (r_state == RX_DATA && w_full) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {r_rx_s2, r_shift[7:1]};
            end
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;
endmodule

// File: rtl/lc3_uart_loader.sv
// Fills LC-3 program memory from a framed UART image and holds the core in reset until it checks out.
// Write issued 1 cycle after the DAT_LO byte; no backpressure, bytes are spaced far apart.
module lc3_uart_loader
    import lc3_pkg::*;
#(
    parameter int         CLK_DIV   = 104,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        uart_rx,
    output logic        ld_we,
    output logic [15:0] ld_add,
    output logic [15:0] ld_data,
    output logic        core_reset_out,
    output logic        load_done,
    output logic        load_error
);
    logic       w_byte_valid, w_frame_err;
    logic [7:0] w_byte;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .rx        (uart_rx),
        .byte_valid(w_byte_valid),
        .byte_data (w_byte),
        .frame_err (w_frame_err)
    );

    ld_state_t   r_state, w_nxt;
    logic [15:0] r_cnt, r_org, r_idx, r_add, r_data;
    logic [7:0]  r_hi, r_sum, w_sum;
    logic        r_we, r_done, r_err, r_core_rst;
    logic        w_wr, w_pass, w_fail;

    always_comb begin
        w_nxt  = r_state;
        w_wr   = 1'b0;
        w_pass = 1'b0;
        w_fail = 1'b0;
        w_sum  = r_sum + w_byte;
        if (w_frame_err && r_state != ST_HUNT && r_state != ST_RUN) begin
            w_nxt  = ST_HUNT;
            w_fail = 1'b1;
        end else if (w_byte_valid) begin
            case (r_state)
                ST_HUNT:   if (w_byte == SYNC_BYTE) w_nxt = ST_CNT_HI;
                ST_CNT_HI: w_nxt = ST_CNT_LO;
                ST_CNT_LO: w_nxt = ST_ORG_HI;
                ST_ORG_HI: w_nxt = ST_ORG_LO;
                ST_ORG_LO: w_nxt = (r_cnt == 16'd0) ? ST_CSUM : ST_DAT_HI;
                ST_DAT_HI: w_nxt = ST_DAT_LO;
                ST_DAT_LO: begin
                    w_wr  = 1'b1;
                    w_nxt = (r_idx + 16'd1 == r_cnt) ? ST_CSUM : ST_DAT_HI;
                end
                ST_CSUM: begin
                    if (w_sum == 8'h00) begin
                        w_pass = 1'b1;
                        w_nxt  = ST_RUN;
                    end else begin
                        w_fail = 1'b1;
                        w_nxt  = ST_HUNT;
                    end
                end
                default: w_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state    <= ST_HUNT;
            r_cnt      <= 16'h0000;
            r_org      <= 16'h0000;
            r_idx      <= 16'h0000;
            r_add      <= 16'h0000;
            r_data     <= 16'h0000;
            r_hi       <= 8'h00;
            r_sum      <= 8'h00;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_state <= w_nxt;
            r_we    <= w_wr;
            r_err   <= w_fail;
            if (w_pass) begin
                r_done     <= 1'b1;
                r_core_rst <= 1'b0;
            end
            // Sum restarts on every HUNT byte so it is zero when the sync byte moves us on.
            if (w_byte_valid && r_state == ST_HUNT)
                r_sum <= 8'h00;
            else if (w_byte_valid && r_state != ST_RUN)
                r_sum <= w_sum;
            if (w_byte_valid) begin
                case (r_state)
                    ST_CNT_HI: r_cnt[15:8] <= w_byte;
                    ST_CNT_LO: r_cnt[7:0]  <= w_byte;
                    ST_ORG_HI: r_org[15:8] <= w_byte;
                    ST_ORG_LO: begin
                        r_org[7:0] <= w_byte;
                        r_idx      <= 16'h0000;
                    end
                    ST_DAT_HI: r_hi <= w_byte;
                    default: ;
                endcase
            end
            if (w_wr) begin
                r_add  <= r_org + r_idx;
                r_data <= {r_hi, w_byte};
                r_idx  <= r_idx + 16'd1;
            end
        end
    end

    assign ld_we          = r_we;
    assign ld_add         = r_add;
    assign ld_data        = r_data;
    assign core_reset_out = r_core_rst;
    assign load_done      = r_done;
    assign load_error     = r_err;
endmodule
